hamming_link_ctrl: RTL and testbench
====================================

Name: hamming_link_ctrl

Overview:
- Transaction sequencer for the Hamming(7,4) encoder -> noise -> decoder link.
- Accepts 4-bit data words on a valid/ready input and launches each word into the encoder.
- Pulses the noise-enable on a programmable schedule, captures the decoder result after the fixed pipeline latency, and returns data, syndrome and pass/fail on a valid/ready output.
- Keeps saturating link-statistics counters; sits between the test/host logic and the encoder/noise/decoder instances.

Parameters:
- LAT, 2, clock edges from an enc_d change until dec_d/dec_s are valid (encoder reg + decoder reg).
- NOISE_OFS, 1, edges after launch at which noise_en rises; must be < LAT.
- CW, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  4  data word d[4:1]
- noise_period  in  8  inject on every Nth accepted word; 0 = never
- enc_d  out  4  registered drive to encoder d
- noise_en  out  1  registered drive to noise en
- dec_s  in  3  decoder syndrome
- dec_d  in  4  decoder corrected data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  4  captured dec_d
- out_syndrome  out  3  captured dec_s
- out_err  out  1  captured dec_d != launched word
- out_noised  out  1  noise was injected for this word
- tx_cnt  out  CW  words completed
- corr_cnt  out  CW  words with dec_s != 0 and data match
- fail_cnt  out  CW  words with data mismatch
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; enc_d=0, noise_en=0, out_valid=0, out_data=0, out_syndrome=0, out_err=0, out_noised=0, all counters=0, noise phase counter=0.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid at edge T0: latch in_data into sent register; enc_d<=in_data; evaluate the noise decision; cycle counter=0; go RUN.
- Noise decision at acceptance:
  - noise_period sampled at acceptance only.
  - If noise_period==0: no injection; phase counter unchanged.
  - Otherwise: inject when phase==noise_period-1, then phase<=0; else phase<=phase+1. noise_period=1 injects on every word.
  - A noise_period change applies from the next acceptance; the phase is clamped to 0 if it is >= the new period.
- RUN:
  - in_ready=0.
  - If injecting, noise_en=1 for exactly one cycle: rises at edge T0+NOISE_OFS, falls at edge T0+NOISE_OFS+1. Otherwise noise_en stays 0.
  - At edge T0+LAT+1, capture dec_d->out_data and dec_s->out_syndrome.
  - Also at that edge: out_err=(dec_d!=sent); out_noised=inject; out_valid<=1; go RESP.
- RESP:
  - Hold outputs stable while out_valid && !out_ready.
  - On out_ready: out_valid<=0; go IDLE.
  - Counters update on this handshake edge: tx_cnt+1; corr_cnt+1 if !out_err && out_syndrome!=0; fail_cnt+1 if out_err.
  - All counters saturate at 2^CW-1 (no wrap).
- in_ready is combinational from state (1 only in IDLE); a new word is never accepted in the same cycle as the RESP handshake.
- Minimum period: LAT+3 cycles per word with out_ready tied high.
- enc_d holds the last launched word until the next acceptance; noise_en is 0 outside RUN.
- in_data and in_valid are ignored while busy; the producer holds them until in_ready.
- Reset asserted mid-RUN or RESP: the transaction is dropped, no counter update, noise_en deasserts immediately.

Test Plan:
- Reset: with rst_n=0, all outputs are 0 and in_ready=1.
- After release: in_data=4'b1001, noise_period=0, out_ready=1 -> noise_en never high. out_valid rises at edge T0+3 (T0 = in_data acceptance edge, T0+LAT+1 with LAT=2). out_data=1001, out_syndrome=000, out_err=0, out_noised=0, tx_cnt=1.
- noise_period=1, words 1001 then 0110:
  - noise_en is high exactly one cycle per word, at T0+1..T0+2.
  - Each result: out_data=sent word, out_syndrome!=000, out_noised=1, out_err=0.
  - After both: corr_cnt=2, fail_cnt=0.
- noise_period=3, six back-to-back words -> out_noised=1 only on words 3 and 6; phase returns to 0 after word 6.
- out_ready held low 5 cycles in RESP -> out_valid, out_data and out_syndrome stable; in_ready=0; counters increment only on the handshake edge.
- rst_n pulsed low during RUN (T0+1) -> noise_en drops asynchronously and the FSM returns to IDLE. No result is produced and tx_cnt stays at its pre-reset value of 0. The next word completes normally.
- Force dec_d to a wrong value via a datapath override (sent 1001) -> out_err=1 and fail_cnt increments. With CW=4 and 16 forced failures, fail_cnt saturates at 15.

Source files
------------

// File: rtl/hamming_link_ctrl.sv
// hamming_link_ctrl: transaction sequencer for a Hamming(7,4) encoder -> noise -> decoder link.
//
// Accepts one 4-bit word at a time, launches it into the encoder, optionally pulses the
// noise enable on a programmable schedule, captures the decoder result after the link
// latency and hands it to the consumer together with link statistics.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   word input handshake (in_ready only in IDLE)
//   noise_period                inject on every Nth accepted word, 0 = never
//   enc_d, noise_en             registered drives to the encoder and noise block
//   dec_s, dec_d                decoder syndrome and corrected data
//   out_valid/out_ready         result handshake
//   out_data, out_syndrome      captured decoder outputs
//   out_err, out_noised         data mismatch flag, noise-injected flag
//   tx_cnt, corr_cnt, fail_cnt  saturating statistics counters
//   busy                        controller is not idle
module hamming_link_ctrl #(
    parameter int LAT       = 2,
    parameter int NOISE_OFS = 1,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_data,
    input  logic [7:0]    noise_period,
    output logic [3:0]    enc_d,
    output logic          noise_en,
    input  logic [2:0]    dec_s,
    input  logic [3:0]    dec_d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_data,
    output logic [2:0]    out_syndrome,
    output logic          out_err,
    output logic          out_noised,
    output logic [CW-1:0] tx_cnt,
    output logic [CW-1:0] corr_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          busy
);
    localparam int CNTW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [CNTW-1:0] CAP_C  = CNTW'(LAT);
    localparam bit              RISE_RUN = NOISE_OFS > 0;
    localparam logic [CNTW-1:0] RISE_C = CNTW'(NOISE_OFS > 0 ? NOISE_OFS - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    sent_q, sent_d;
    logic [3:0]    enc_q, enc_nx;
    logic          noise_q, noise_d;
    logic          inj_q, inj_d;
    logic [7:0]    phase_q, phase_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d;
    logic [3:0]    od_q, od_d;
    logic [2:0]    os_q, os_d;
    logic          oe_q, oe_d;
    logic          on_q, on_d;
    logic [CW-1:0] tx_q, tx_d;
    logic [CW-1:0] corr_q, corr_d;
    logic [CW-1:0] fail_q, fail_d;
    logic [7:0]    phase_eff;
    logic          inj_now;

    // A shrunken period must not leave the phase beyond its new range.
    assign phase_eff = (phase_q >= noise_period) ? 8'd0 : phase_q;
    assign inj_now   = (noise_period != 8'd0) && (phase_eff == noise_period - 8'd1);

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        enc_nx  = enc_q;
        noise_d = 1'b0;
        inj_d   = inj_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        os_d    = os_q;
        oe_d    = oe_q;
        on_d    = on_q;
        tx_d    = tx_q;
        corr_d  = corr_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sent_d  = in_data;
                    enc_nx  = in_data;
                    inj_d   = inj_now;
                    phase_d = (noise_period == 8'd0) ? phase_q : (inj_now ? 8'd0 : phase_eff + 8'd1);
                    cnt_d   = '0;
                    noise_d = inj_now && !RISE_RUN;
                    state_d = RUN;
                end
            end
            RUN: begin
                // cnt_q holds (edges since launch - 1), so the compare fires one edge late by design.
                cnt_d   = cnt_q + CNTW'(1);
                noise_d = inj_q && RISE_RUN && (cnt_q == RISE_C);
                if (cnt_q == CAP_C) begin
                    od_d    = dec_d;
                    os_d    = dec_s;
                    oe_d    = dec_d != sent_q;
                    on_d    = inj_q;
                    ov_d    = 1'b1;
                    noise_d = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                    tx_d    = (&tx_q) ? tx_q : tx_q + CW'(1);
                    corr_d  = (!oe_q && os_q != 3'd0 && !(&corr_q)) ? corr_q + CW'(1) : corr_q;
                    fail_d  = (oe_q && !(&fail_q)) ? fail_q + CW'(1) : fail_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sent_q  <= '0;
            enc_q   <= '0;
            noise_q <= 1'b0;
            inj_q   <= 1'b0;
            phase_q <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= '0;
            oe_q    <= 1'b0;
            on_q    <= 1'b0;
            tx_q    <= '0;
            corr_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            enc_q   <= enc_nx;
            noise_q <= noise_d;
            inj_q   <= inj_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
            oe_q    <= oe_d;
            on_q    <= on_d;
            tx_q    <= tx_d;
            corr_q  <= corr_d;
            fail_q  <= fail_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign busy         = state_q != IDLE;
    assign enc_d        = enc_q;
    assign noise_en     = noise_q;
    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign out_syndrome = os_q;
    assign out_err      = oe_q;
    assign out_noised   = on_q;
    assign tx_cnt       = tx_q;
    assign corr_cnt     = corr_q;
    assign fail_cnt     = fail_q;
endmodule

// File: tb/tb_hamming_link_ctrl.sv
// tb_hamming_link_ctrl: directed vector bench for hamming_link_ctrl with a behavioural Hamming(7,4) link.
module tb_hamming_link_ctrl;
    localparam int CW = 4;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [3:0] in_data = 0;
    logic [7:0] noise_period = 0;
    logic in_ready, noise_en, out_valid, out_err, out_noised, busy;
    logic [3:0] enc_d, out_data;
    logic [2:0] out_syndrome;
    logic [CW-1:0] tx_cnt, corr_cnt, fail_cnt;

    logic [6:0] cw_q = '0;
    logic [3:0] dec_d = '0;
    logic [2:0] dec_s = '0;
    logic [6:0] noisy;
    int flip_pos = 3;
    logic force_wrong = 0;

    int n_tests = 0, n_fail = 0;
    int tx_m = 0, corr_m = 0, fail_m = 0;

    hamming_link_ctrl #(.LAT(2), .NOISE_OFS(1), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .noise_period(noise_period), .enc_d(enc_d), .noise_en(noise_en), .dec_s(dec_s), .dec_d(dec_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
        .out_err(out_err), .out_noised(out_noised), .tx_cnt(tx_cnt), .corr_cnt(corr_cnt),
        .fail_cnt(fail_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Codeword bit i is Hamming position i+1: p1 p2 d1 p4 d2 d3 d4.
    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [2:0] syn(input logic [6:0] c);
        return {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
    endfunction

    function automatic logic [3:0] fix(input logic [6:0] c);
        logic [6:0] t;
        logic [2:0] s;
        t = c;
        s = syn(c);
        if (s != 3'd0) t[int'(s) - 1] = ~t[int'(s) - 1];
        return {t[6], t[5], t[4], t[2]};
    endfunction

    assign noisy = cw_q ^ (noise_en ? 7'(1 << (flip_pos - 1)) : 7'd0);

    always @(posedge clk) begin
        cw_q  <= encode(enc_d);
        dec_s <= syn(noisy);
        dec_d <= fix(noisy) ^ {4{force_wrong}};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] data;
        logic [7:0] np;
        int         flip;
        logic       frc;
        int         hold;
        logic [3:0] e_data;
        logic [2:0] e_syn;
        logic       e_err;
        logic       e_noised;
    } vec_t;

    vec_t tv[$];

    task automatic run(input vec_t v);
        int k;
        logic [31:0] nmask;
        logic [3:0] hd;
        logic [2:0] hs;
        noise_period = v.np;
        flip_pos = v.flip;
        force_wrong = v.frc;
        out_ready = (v.hold == 0);
        in_data = v.data;
        in_valid = 1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        k = 0;
        nmask = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (noise_en) nmask[k] = 1'b1;
        end while (!out_valid && k < 20);
        chk("latency", k, 3);
        chk("noise_en_window", nmask, v.e_noised ? 32'd2 : 32'd0);
        chk("out_data", out_data, v.e_data);
        chk("out_syndrome", out_syndrome, v.e_syn);
        chk("out_err", out_err, v.e_err);
        chk("out_noised", out_noised, v.e_noised);
        hd = out_data;
        hs = out_syndrome;
        repeat (v.hold) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, hd);
            chk("stall_syn", out_syndrome, hs);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_tx", tx_cnt, tx_m);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        tx_m = (tx_m < 15) ? tx_m + 1 : 15;
        if (!v.e_err && v.e_syn != 0) corr_m = (corr_m < 15) ? corr_m + 1 : 15;
        if (v.e_err) fail_m = (fail_m < 15) ? fail_m + 1 : 15;
        chk("hs_valid_low", out_valid, 0);
        chk("tx_cnt", tx_cnt, tx_m);
        chk("corr_cnt", corr_cnt, corr_m);
        chk("fail_cnt", fail_cnt, fail_m);
        force_wrong = 0;
    endtask

    initial begin
        int seen;
        tv.push_back('{4'b1001, 8'd0, 3, 1'b0, 0, 4'b1001, 3'd0, 1'b0, 1'b0});
        tv.push_back('{4'b1001, 8'd1, 3, 1'b0, 0, 4'b1001, 3'd3, 1'b0, 1'b1});
        tv.push_back('{4'b0110, 8'd1, 6, 1'b0, 0, 4'b0110, 3'd6, 1'b0, 1'b1});
        tv.push_back('{4'b0001, 8'd3, 5, 1'b0, 0, 4'b0001, 3'd0, 1'b0, 1'b0});
        tv.push_back('{4'b0010, 8'd3, 5, 1'b0, 0, 4'b0010, 3'd0, 1'b0, 1'b0});
        tv.push_back('{4'b0011, 8'd3, 5, 1'b0, 0, 4'b0011, 3'd5, 1'b0, 1'b1});
        tv.push_back('{4'b0100, 8'd3, 5, 1'b0, 0, 4'b0100, 3'd0, 1'b0, 1'b0});
        tv.push_back('{4'b0101, 8'd3, 5, 1'b0, 0, 4'b0101, 3'd0, 1'b0, 1'b0});
        tv.push_back('{4'b1111, 8'd3, 5, 1'b0, 0, 4'b1111, 3'd5, 1'b0, 1'b1});
        tv.push_back('{4'b1010, 8'd3, 5, 1'b0, 5, 4'b1010, 3'd0, 1'b0, 1'b0});
        for (int i = 0; i < 16; i++) begin
            logic [3:0] d;
            d = 4'(i);
            tv.push_back('{d, 8'd0, 3, 1'b1, 0, ~d, 3'd0, 1'b1, 1'b0});
        end

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outs", {enc_d, noise_en, out_valid, out_data, out_syndrome, out_err, out_noised, busy}, 0);
        chk("rst_cnts", {tx_cnt, corr_cnt, fail_cnt}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        noise_period = 1;
        flip_pos = 3;
        in_data = 4'b1001;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        chk("midrst_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("midrst_noise_hi", noise_en, 1);
        #1 rst_n = 0;
        #1;
        chk("midrst_noise_lo", noise_en, 0);
        chk("midrst_idle", {busy, in_ready}, 2'b01);
        chk("midrst_tx", tx_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        chk("midrst_no_result", seen, 0);
        chk("midrst_tx_after", tx_cnt, 0);
        @(negedge clk);

        foreach (tv[i]) run(tv[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
